// File: rtl/regfile_mp_sb_pkg.sv
// Package for the multi-port integer register file.
// Contents: default address/data widths, register address/data typedefs, and
// architectural register constants (x0 hard-wired zero, a0 debug tap).
// Optional feature macro used by the top: REGFILE_BYPASS_EN.
package regfile_pkg;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 32;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = '0;
  localparam reg_addr_t REG_A0   = reg_addr_t'(10);
endpackage

// File: rtl/regfile_mp_sb_if.sv
// Register-file bus interface: read ports, two write ports, reserve port and
// status outputs grouped as one bundle.
//   master : decode/writeback side (drives addresses, writes, reserves)
//   slave  : the register file (drives read data, busy, pend_cnt, conflict, dbg)
// Signals:
//   rd_addr  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data  NUM_RD*DATA_W  combinational read data
//   rd_busy  NUM_RD         addressed register has a pending write
//   wr0_*    ALU writeback port;  wr1_* load writeback port (priority)
//   rsv_*    reserve destination register at issue
//   pend_cnt ADDR_W+1       number of pending registers
//   wr_conflict             1-cycle pulse after both ports hit same nonzero addr
//   dbg_data                contents of the debug register
interface regfile_mp_sb_if
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [ADDR_W:0]          pend_cnt;
  logic                     wr_conflict;
  logic [DATA_W-1:0]        dbg_data;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           rsv_en, rsv_addr,
    input  rd_data, rd_busy, pend_cnt, wr_conflict, dbg_data
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           rsv_en, rsv_addr,
    output rd_data, rd_busy, pend_cnt, wr_conflict, dbg_data
  );
endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus an incrementally
// maintained occupancy count.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   rsv_en_i/rsv_addr_i     mark register pending (x0 ignored)
//   wr0_en_i/wr0_addr_i     retire via write port 0
//   wr1_en_i/wr1_addr_i     retire via write port 1
//   busy_o                  registered busy vector
//   pend_cnt_o              registered popcount of busy_o
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rsv_en_i,
  input  logic [ADDR_W-1:0]      rsv_addr_i,
  input  logic                   wr0_en_i,
  input  logic [ADDR_W-1:0]      wr0_addr_i,
  input  logic                   wr1_en_i,
  input  logic [ADDR_W-1:0]      wr1_addr_i,
  output logic [2**ADDR_W-1:0]   busy_o,
  output logic [ADDR_W:0]        pend_cnt_o
);
  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             rsv_v, wr0_v, wr1_v;
  logic             inc, dec0, dec1;

  always_comb begin
    rsv_v = rsv_en_i && (rsv_addr_i != '0);
    wr0_v = wr0_en_i && (wr0_addr_i != '0);
    wr1_v = wr1_en_i && (wr1_addr_i != '0);

    busy_d = busy_q;
    if (wr0_v) busy_d[wr0_addr_i] = 1'b0;
    if (wr1_v) busy_d[wr1_addr_i] = 1'b0;
    // Reserve applied last: a same-cycle new owner keeps the bit set.
    if (rsv_v) busy_d[rsv_addr_i] = 1'b1;

    // Count deltas mirror the bit transitions above; a bit cleared by both
    // write ports, or cleared and re-reserved, must not be counted twice.
    inc  = rsv_v && !busy_q[rsv_addr_i];
    dec0 = wr0_v && busy_q[wr0_addr_i] &&
           !(rsv_v && (rsv_addr_i == wr0_addr_i));
    dec1 = wr1_v && busy_q[wr1_addr_i] &&
           !(rsv_v && (rsv_addr_i == wr1_addr_i)) &&
           !(wr0_v && (wr0_addr_i == wr1_addr_i));
    cnt_d = cnt_q + CW'(inc) - CW'(dec0) - CW'(dec1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign pend_cnt_o = cnt_q;
endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with hard-wired x0, two synchronous write
// ports (port 1 has priority), NUM_RD combinational read ports, a pending-write
// scoreboard and a registered write-conflict pulse.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bus          regfile_mp_sb_if.slave (reads, writes, reserve, status, dbg)
// Configuration macro: REGFILE_BYPASS_EN -- when defined, reads, rd_busy and
// dbg_data see same-cycle writes; otherwise they reflect registered state only.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned DBG_REG = int'(REG_A0)
)(
  input  logic           clk,
  input  logic           rst_n,
  regfile_mp_sb_if.slave bus
);
  localparam int unsigned       DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] DBG_IDX = ADDR_W'(DBG_REG);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [ADDR_W:0]   pend_cnt;
  logic              wr0_v, wr1_v;
  logic              wr_conflict_q;

  assign wr0_v = bus.wr0_en && (bus.wr0_addr != '0);
  assign wr1_v = bus.wr1_en && (bus.wr1_addr != '0);

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .rsv_en_i   (bus.rsv_en),
    .rsv_addr_i (bus.rsv_addr),
    .wr0_en_i   (bus.wr0_en),
    .wr0_addr_i (bus.wr0_addr),
    .wr1_en_i   (bus.wr1_en),
    .wr1_addr_i (bus.wr1_addr),
    .busy_o     (busy),
    .pend_cnt_o (pend_cnt)
  );

  // Port 1 is written second so it wins when both ports hit the same address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      if (wr0_v) mem_q[bus.wr0_addr] <= bus.wr0_data;
      if (wr1_v) mem_q[bus.wr1_addr] <= bus.wr1_data;
      wr_conflict_q <= wr0_v && wr1_v && (bus.wr0_addr == bus.wr1_addr);
    end
  end

  function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = mem_q[a];
`ifdef REGFILE_BYPASS_EN
    if (wr0_v && (bus.wr0_addr == a)) v = bus.wr0_data;
    if (wr1_v && (bus.wr1_addr == a)) v = bus.wr1_data;
`endif
    if (a == '0) v = '0;
    return v;
  endfunction

  function automatic logic read_busy(input logic [ADDR_W-1:0] a);
    logic b;
    b = busy[a];
`ifdef REGFILE_BYPASS_EN
    // A retiring write frees the register now unless it is re-reserved.
    if ((wr0_v && (bus.wr0_addr == a)) || (wr1_v && (bus.wr1_addr == a)))
      b = bus.rsv_en && (bus.rsv_addr == a);
`endif
    return b;
  endfunction

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      bus.rd_data[i*DATA_W +: DATA_W] = read_data(bus.rd_addr[i*ADDR_W +: ADDR_W]);
      bus.rd_busy[i]                  = read_busy(bus.rd_addr[i*ADDR_W +: ADDR_W]);
    end
    bus.dbg_data = read_data(DBG_IDX);
  end

  assign bus.pend_cnt    = pend_cnt;
  assign bus.wr_conflict = wr_conflict_q;
endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp_sb_if #(.ADDR_W(5), .DATA_W(32), .NUM_RD(2)) bus ();

  regfile_mp_sb #(
    .ADDR_W  (5),
    .DATA_W  (32),
    .NUM_RD  (2),
    .DBG_REG (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural model: architectural register contents, set of pending
  // registers, and last-cycle conflict flag.
  logic [31:0] m_mem [32];
  logic [31:0] m_busy;
  logic        m_conf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_mem[i] <= '0;
      m_busy <= '0;
      m_conf <= 1'b0;
    end else begin
      m_conf <= bus.wr0_en && bus.wr1_en && (bus.wr0_addr == bus.wr1_addr) &&
                (bus.wr0_addr != '0);
      if (bus.wr0_en && bus.wr0_addr != '0) begin
        m_mem[bus.wr0_addr]  <= bus.wr0_data;
        m_busy[bus.wr0_addr] <= 1'b0;
      end
      if (bus.wr1_en && bus.wr1_addr != '0) begin
        m_mem[bus.wr1_addr]  <= bus.wr1_data;
        m_busy[bus.wr1_addr] <= 1'b0;
      end
      if (bus.rsv_en && bus.rsv_addr != '0) m_busy[bus.rsv_addr] <= 1'b1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wr1_en && bus.wr1_addr == a) return bus.wr1_data;
    if (bus.wr0_en && bus.wr0_addr == a) return bus.wr0_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == '0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if ((bus.wr1_en && bus.wr1_addr == a) || (bus.wr0_en && bus.wr0_addr == a))
      return bus.rsv_en && bus.rsv_addr == a;
`endif
    return m_busy[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("rd_data%0d", p), bus.rd_data[p*32 +: 32],
              exp_rd(bus.rd_addr[p*5 +: 5]));
        check($sformatf("rd_busy%0d", p), 32'(bus.rd_busy[p]),
              32'(exp_busy(bus.rd_addr[p*5 +: 5])));
      end
      check("pend_cnt", 32'(bus.pend_cnt), 32'($countones(m_busy)));
      check("wr_conflict", 32'(bus.wr_conflict), 32'(m_conf));
      check("dbg_data", bus.dbg_data, exp_rd(5'd10));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr0_en = 1'b0;
    bus.wr1_en = 1'b0;
    bus.rsv_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    bus.wr0_en = 1'b1; bus.wr0_addr = a; bus.wr0_data = d;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    bus.wr1_en = 1'b1; bus.wr1_addr = a; bus.wr1_data = d;
  endtask

  task automatic rsv(input logic [4:0] a);
    bus.rsv_en = 1'b1; bus.rsv_addr = a;
  endtask

  initial begin
    idle();
    bus.wr0_addr = '0; bus.wr0_data = '0;
    bus.wr1_addr = '0; bus.wr1_data = '0;
    bus.rsv_addr = '0;
    rd(5'd0, 5'd0);
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    #1;
    check("reset_pend", 32'(bus.pend_cnt), 32'd0);
    check("reset_busy", 32'(bus.rd_busy), 32'd0);
    check("reset_conf", 32'(bus.wr_conflict), 32'd0);
    check("reset_dbg", bus.dbg_data, 32'd0);
    #19 rst_n = 1'b1;

    // Test 1: every register reads zero after reset.
    for (int i = 0; i < 32; i++) begin
      tick();
      rd(5'(i), 5'(31 - i));
      #2;
      check("t1_rd0", bus.rd_data[31:0], 32'd0);
      check("t1_busy", 32'(bus.rd_busy), 32'd0);
    end

    // Test 2: write/readback and x0 discard.
    tick(); wr0(5'd5, 32'hDEADBEEF); rd(5'd5, 5'd0);
    tick(); idle(); #2;
    check("t2_x5", bus.rd_data[31:0], 32'hDEADBEEF);
    wr0(5'd0, 32'h1234); rd(5'd0, 5'd5);
    tick(); idle(); #2;
    check("t2_x0", bus.rd_data[31:0], 32'd0);

    // Test 3: same-address double write; port 1 wins, one-cycle conflict pulse.
    wr0(5'd7, 32'h11); wr1(5'd7, 32'h22);
    tick(); idle(); rd(5'd7, 5'd0); #2;
    check("t3_x7", bus.rd_data[31:0], 32'h22);
    check("t3_conf_hi", 32'(bus.wr_conflict), 32'd1);
    tick(); #2;
    check("t3_conf_lo", 32'(bus.wr_conflict), 32'd0);

    // Test 4: scoreboard reserve/retire.
    rsv(5'd3); tick();
    rsv(5'd3); tick(); #2;
    check("t4_reres", 32'(bus.pend_cnt), 32'd1);
    rsv(5'd0); tick(); #2;
    check("t4_x0rsv", 32'(bus.pend_cnt), 32'd1);
    rsv(5'd4); tick(); idle(); rd(5'd3, 5'd4); #2;
    check("t4_pend2", 32'(bus.pend_cnt), 32'd2);
    check("t4_busy3", 32'(bus.rd_busy[0]), 32'd1);
    wr0(5'd3, 32'h3); wr1(5'd4, 32'h4);
    tick(); idle(); #2;
    check("t4_pend0", 32'(bus.pend_cnt), 32'd0);
    wr0(5'd9, 32'h9); tick(); idle(); #2;
    check("t4_nonbusy_wr", 32'(bus.pend_cnt), 32'd0);
    rsv(5'd3); wr0(5'd3, 32'h33);
    tick(); idle(); rd(5'd3, 5'd0); #2;
    check("t4_keep_busy", 32'(bus.rd_busy[0]), 32'd1);
    check("t4_pend1", 32'(bus.pend_cnt), 32'd1);
    wr0(5'd3, 32'h333); tick(); idle(); #2;
    check("t4_clear", 32'(bus.pend_cnt), 32'd0);

    // Test 5: write of x10 visible same cycle only with bypass.
    rd(5'd0, 5'd10); wr1(5'd10, 32'hA5A5); #2;
`ifdef REGFILE_BYPASS_EN
    check("t5_rd_now", bus.rd_data[63:32], 32'hA5A5);
    check("t5_dbg_now", bus.dbg_data, 32'hA5A5);
`else
    check("t5_rd_old", bus.rd_data[63:32], 32'd0);
    check("t5_dbg_old", bus.dbg_data, 32'd0);
`endif
    tick(); idle(); #2;
    check("t5_rd_next", bus.rd_data[63:32], 32'hA5A5);
    check("t5_dbg_next", bus.dbg_data, 32'hA5A5);

    // Test 6: asynchronous reset mid-cycle drops pending state and data.
    for (int r = 11; r < 17; r++) begin
      rsv(5'(r)); tick();
    end
    idle(); rd(5'd11, 5'd5); #1;
    check("t6_pend6", 32'(bus.pend_cnt), 32'd6);
    #2 rst_n = 1'b0;
    #1;
    check("t6_pend_rst", 32'(bus.pend_cnt), 32'd0);
    check("t6_busy_rst", 32'(bus.rd_busy), 32'd0);
    check("t6_x5_rst", bus.rd_data[63:32], 32'd0);
    check("t6_dbg_rst", bus.dbg_data, 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;

    // Mixed traffic over a small address range to force collisions.
    for (int n = 0; n < 80; n++) begin
      tick();
      idle();
      rd(5'($urandom_range(0, 7)), 5'($urandom_range(8, 11)));
      if ($urandom_range(0, 1) == 1) wr0(5'($urandom_range(0, 11)), $urandom);
      if ($urandom_range(0, 2) == 0) wr1(5'($urandom_range(0, 11)), $urandom);
      if ($urandom_range(0, 1) == 1) rsv(5'($urandom_range(0, 11)));
    end
    tick(); idle();
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
